// File: rtl/ebus_diag_pkg.sv
// Shared types and EBUS diagnostic function codes for the console-side diag master.
package ebus_diag_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        RESP   = 3'd4
    } diag_state_e;

    localparam logic [0:6] DIAG_CLR_RUN       = 7'o010;
    localparam logic [0:6] DIAG_SET_RUN       = 7'o011;
    localparam logic [0:6] DIAG_CONTINUE      = 7'o012;
    localparam logic [0:6] DIAG_IR_STROBE     = 7'o014;
    localparam logic [0:6] DIAG_DRAM_STROBE   = 7'o015;
    localparam logic [0:6] DIAG_READ_CON_BASE = 7'o130;

endpackage

// File: rtl/ebus_diag_master.sv
// EBUS diagnostic initiator: sequences SETUP -> STROBE -> HOLD -> RESP per request.
// Optional read parity checking is enabled with `define EBUS_DIAG_PARITY_CHECK_EN.
module ebus_diag_master
    import ebus_diag_pkg::*;
#(
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 2
) (
    input  logic        clk,
    input  logic        RESET_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [0:6]  req_func,
    input  logic [0:35] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [0:35] rsp_rdata,
    output logic        rsp_perr,
    output logic [0:6]  EBUS_ds,
    output logic        EBUS_diagStrobe,
    output logic        EBUS_driving,
    output logic [0:35] EBUS_data_out,
    input  logic [0:35] EBUS_data_in,
    input  logic        EBUS_parity_in
);

    localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYC - 1);

    a_setup_cyc_legal: assert property (@(posedge clk) (SETUP_CYC >= 1) && (SETUP_CYC <= 15));
    a_strobe_cyc_legal: assert property (@(posedge clk) (STROBE_CYC >= 1) && (STROBE_CYC <= 15));

    diag_state_e r_state;
    diag_state_e w_next_state;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic        w_accept;
    logic        w_capture;
    logic        w_bus_next;

    logic        r_req_ready;
    logic        r_rsp_valid;
    logic [0:35] r_rdata;
    logic [0:6]  r_ds;
    logic        r_strobe;
    logic        r_driving;
    logic [0:35] r_data_out;
    logic        r_is_read;

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!RESET_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = SETUP;
                    w_cnt_next   = SETUP_LOAD;
                end
            end
            SETUP: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = STROBE;
                    w_cnt_next   = STROBE_LOAD;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            STROBE: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = HOLD;
                    w_capture    = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            HOLD:    w_next_state = RESP;
            RESP:    if (rsp_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    assign w_bus_next = (w_next_state == SETUP) || (w_next_state == STROBE) ||
                        (w_next_state == HOLD);

    // Outputs are registered from the next state, so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (!RESET_n) begin
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
            r_ds        <= '0;
            r_strobe    <= 1'b0;
            r_driving   <= 1'b0;
            r_data_out  <= '0;
            r_is_read   <= 1'b0;
        end else begin
            r_req_ready <= (w_next_state == IDLE);
            r_rsp_valid <= (w_next_state == RESP);
            r_strobe    <= (w_next_state == STROBE);
            if (w_accept) begin
                r_ds       <= req_func;
                r_is_read  <= req_func[0];
                r_driving  <= ~req_func[0];
                r_data_out <= req_func[0] ? '0 : req_wdata;
                r_rdata    <= '0;
            end else if (!w_bus_next) begin
                r_ds       <= '0;
                r_driving  <= 1'b0;
                r_data_out <= '0;
            end
            if (w_capture && r_is_read) begin
                r_rdata <= EBUS_data_in;
            end
        end
    end

`ifdef EBUS_DIAG_PARITY_CHECK_EN
    logic r_perr;

    // Odd parity over the 36 data bits plus the parity bit is the good case.
    always_ff @(posedge clk) begin
        if (!RESET_n) begin
            r_perr <= 1'b0;
        end else if (w_accept) begin
            r_perr <= 1'b0;
        end else if (w_capture && r_is_read) begin
            r_perr <= ~(^EBUS_data_in ^ EBUS_parity_in);
        end
    end

    assign rsp_perr = r_perr;
`else
    logic w_unused_parity;
    assign w_unused_parity = EBUS_parity_in;
    assign rsp_perr        = 1'b0;
`endif

    assign req_ready       = r_req_ready;
    assign rsp_valid       = r_rsp_valid;
    assign rsp_rdata       = r_rdata;
    assign EBUS_ds         = r_ds;
    assign EBUS_diagStrobe = r_strobe;
    assign EBUS_driving    = r_driving;
    assign EBUS_data_out   = r_data_out;

endmodule

// File: tb/tb_ebus_diag_master.sv
// Randomized self-checking bench: two instances (2/2 and 1/3 dwell) run in lockstep against a cycle model.
module tb_ebus_diag_master;
    import ebus_diag_pkg::*;

    logic        clk = 1'b0;
    logic        RESET_n;
    logic        req_valid;
    logic [0:6]  req_func;
    logic [0:35] req_wdata;
    logic        rsp_ready;
    logic [0:35] EBUS_data_in;
    logic        EBUS_parity_in;

    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_perr;
    logic [1:0]  strobe;
    logic [1:0]  driving;
    logic [0:35] rsp_rdata [2];
    logic [0:35] data_out  [2];
    logic [0:6]  ds        [2];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ebus_diag_master #(.SETUP_CYC(2), .STROBE_CYC(2)) u_dut_a (
        .clk(clk), .RESET_n(RESET_n),
        .req_valid(req_valid), .req_ready(req_ready[0]),
        .req_func(req_func), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata[0]), .rsp_perr(rsp_perr[0]),
        .EBUS_ds(ds[0]), .EBUS_diagStrobe(strobe[0]),
        .EBUS_driving(driving[0]), .EBUS_data_out(data_out[0]),
        .EBUS_data_in(EBUS_data_in), .EBUS_parity_in(EBUS_parity_in)
    );

    ebus_diag_master #(.SETUP_CYC(1), .STROBE_CYC(3)) u_dut_b (
        .clk(clk), .RESET_n(RESET_n),
        .req_valid(req_valid), .req_ready(req_ready[1]),
        .req_func(req_func), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata[1]), .rsp_perr(rsp_perr[1]),
        .EBUS_ds(ds[1]), .EBUS_diagStrobe(strobe[1]),
        .EBUS_driving(driving[1]), .EBUS_data_out(data_out[1]),
        .EBUS_data_in(EBUS_data_in), .EBUS_parity_in(EBUS_parity_in)
    );

    function automatic int setup_of(int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic int strobe_of(int i);
        return (i == 0) ? 2 : 3;
    endfunction

    function automatic logic [35:0] rand36();
        return 36'({$urandom(), $urandom()});
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Idle bus with no response pending; after reset the response fields are cleared too.
    task automatic check_idle(input string tag, input bit after_reset);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s.req_ready[%0d]", tag, i), 64'(req_ready[i]), 64'd1);
            check($sformatf("%s.rsp_valid[%0d]", tag, i), 64'(rsp_valid[i]), 64'd0);
            check($sformatf("%s.ds[%0d]", tag, i), 64'(ds[i]), 64'd0);
            check($sformatf("%s.strobe[%0d]", tag, i), 64'(strobe[i]), 64'd0);
            check($sformatf("%s.driving[%0d]", tag, i), 64'(driving[i]), 64'd0);
            check($sformatf("%s.data_out[%0d]", tag, i), 64'(data_out[i]), 64'd0);
            if (after_reset) begin
                check($sformatf("%s.rdata[%0d]", tag, i), 64'(rsp_rdata[i]), 64'd0);
                check($sformatf("%s.perr[%0d]", tag, i), 64'(rsp_perr[i]), 64'd0);
            end
        end
    endtask

    // Cycle c counts from 1 = first cycle after the accepting edge.
    task automatic check_busy(input int c, input logic [6:0] f, input logic [35:0] wd,
                              input logic [35:0] rd_exp, input logic perr_exp);
        for (int i = 0; i < 2; i++) begin
            int  s     = setup_of(i);
            int  b     = strobe_of(i);
            bit  resp  = (c > s + b + 1);
            bit  write = (f < 7'o100);
            bit  drv   = !resp && write;
            check($sformatf("c%0d.req_ready[%0d]", c, i), 64'(req_ready[i]), 64'd0);
            check($sformatf("c%0d.ds[%0d]", c, i), 64'(ds[i]), resp ? 64'd0 : 64'(f));
            check($sformatf("c%0d.strobe[%0d]", c, i), 64'(strobe[i]), 64'(c > s && c <= s + b));
            check($sformatf("c%0d.driving[%0d]", c, i), 64'(driving[i]), 64'(drv));
            check($sformatf("c%0d.data_out[%0d]", c, i), 64'(data_out[i]), drv ? 64'(wd) : 64'd0);
            check($sformatf("c%0d.rsp_valid[%0d]", c, i), 64'(rsp_valid[i]), 64'(resp));
            if (resp) begin
                check($sformatf("c%0d.rdata[%0d]", c, i), 64'(rsp_rdata[i]), 64'(rd_exp));
                check($sformatf("c%0d.perr[%0d]", c, i), 64'(rsp_perr[i]), 64'(perr_exp));
            end
        end
    endtask

    // One request from acceptance to return to idle; bp = extra RESP cycles with rsp_ready low,
    // rst_cyc != 0 pulls reset low during that cycle.
    task automatic run_txn(input logic [6:0] f, input logic [35:0] wd, input logic [35:0] rdat,
                           input logic par, input int bp, input int rst_cyc);
        int          total = setup_of(0) + strobe_of(0) + 2;
        int          cap   = setup_of(0) + strobe_of(0);
        bit          is_rd = (f >= 7'o100);
        logic [35:0] rd_exp;
        logic        perr_exp;
        rd_exp = is_rd ? rdat : 36'd0;
`ifdef EBUS_DIAG_PARITY_CHECK_EN
        perr_exp = is_rd && ((($countones(rdat) + int'(par)) % 2) == 0);
`else
        perr_exp = 1'b0;
`endif
        req_valid = 1'b1;
        req_func  = f;
        req_wdata = wd;
        rsp_ready = 1'b0;
        for (int c = 1; c <= total + bp; c++) begin
            @(posedge clk);
            @(negedge clk);
            req_valid      = 1'($urandom_range(0, 1));
            req_func       = 7'($urandom());
            req_wdata      = rand36();
            EBUS_data_in   = (c == cap) ? rdat : rand36();
            EBUS_parity_in = (c == cap) ? par : 1'($urandom_range(0, 1));
            rsp_ready      = (c < total) ? 1'($urandom_range(0, 1)) : (c == total + bp);
            if (c == rst_cyc) RESET_n = 1'b0;
            check_busy(c, f, wd, rd_exp, perr_exp);
            if (c == rst_cyc) begin
                @(posedge clk);
                @(negedge clk);
                RESET_n   = 1'b1;
                req_valid = 1'b0;
                rsp_ready = 1'b1;
                check_idle("post_reset", 1'b1);
                for (int k = 0; k < total + 2; k++) begin
                    @(posedge clk);
                    @(negedge clk);
                    check($sformatf("no_rsp_after_reset_k%0d", k), 64'(rsp_valid), 64'd0);
                end
                rsp_ready = 1'b0;
                return;
            end
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        check_idle("done", 1'b0);
    endtask

    initial begin
        RESET_n        = 1'b0;
        req_valid      = 1'b0;
        req_func       = '0;
        req_wdata      = '0;
        rsp_ready      = 1'b0;
        EBUS_data_in   = '0;
        EBUS_parity_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("in_reset", 1'b1);
        RESET_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle("after_reset", 1'b1);

        run_txn(DIAG_SET_RUN, rand36(), rand36(), 1'b0, 0, 0);
        run_txn(7'o131, rand36(), 36'o123456701234, 1'b1, 0, 0);
        run_txn(DIAG_READ_CON_BASE, rand36(), rand36(), 1'b0, 5, 0);
        run_txn(DIAG_CONTINUE, rand36(), rand36(), 1'b0, 0, 3);
        run_txn(7'o131, rand36(), 36'o000000000003, 1'b0, 0, 0);
        run_txn(7'o131, rand36(), 36'o000000000003, 1'b1, 0, 0);
        run_txn(DIAG_CLR_RUN, 36'o777777777777, rand36(), 1'b1, 2, 0);
        run_txn(DIAG_IR_STROBE, rand36(), rand36(), 1'b0, 1, 0);
        run_txn(DIAG_DRAM_STROBE, rand36(), rand36(), 1'b1, 0, 6);

        for (int n = 0; n < 60; n++) begin
            logic [6:0] f;
            int         bp;
            int         rc;
            f  = 7'($urandom());
            bp = $urandom_range(0, 5);
            rc = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 6 + bp) : 0;
            run_txn(f, rand36(), rand36(), 1'($urandom_range(0, 1)), bp, rc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
